// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package serial_addsub_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Control state encoding, fixed so external tools can decode the state bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width. One extra bit above clog2 so that WIDTH itself is
  // representable even when WIDTH is a power of two.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell used by the serial datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term shared by the sum and the carry.
  assign p    = x ^ y;
  assign s    = p ^ cin;
  assign cout = (x & y) | (cin & p);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial a+b / a-b, one bit per cycle through a single full-adder cell.
// Latency: start sampled at edge k -> done pulses for one cycle after edge k+WIDTH.
// Backpressure: none; start is accepted in IDLE or DONE, ignored while busy.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;
  logic             take;

  // The LSBs of the operand shift registers and the carry flop feed the
  // one and only adder cell; everything else is sequencing around it.
  fa_bit u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // The RUN edge that processes the MSB; carries are captured on this edge.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // A new request is accepted in IDLE and also in DONE for back-to-back use.
  assign take = start && ((state == IDLE) || (state == DONE));

  // Operand datapath: load on accept, shift one bit right per RUN edge.
  // Subtraction is a + ~b + 1, so B is inverted and the carry seeded with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (take) begin
      a_sh  <= a;
      b_sh  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
    end
  end

  // Control FSM with registered status and result outputs. The result
  // register doubles as the sum shift register: after WIDTH shifts the
  // first sum bit has arrived at bit 0 and the word is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          result <= {fa_s, result[WIDTH-1:1]};
          if (last_bit) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            carry_out <= fa_cout;
            // Carry into the MSB is the carry flop at this point.
            overflow  <= carry ^ fa_cout;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on rising clk edge.
REQ-005 sub  input  1  operation select, sampled with start: 0 = a+b, 1 = a-b.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while bits are being processed (RUN state).
REQ-009 done  output  1  one-cycle pulse; result, carry_out and overflow are valid.
REQ-010 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-011 carry_out  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-012 overflow  output  1  two's-complement signed overflow.

Function
REQ-013 FSM states: IDLE, RUN, DONE; one bit per cycle, LSB first, through one full-adder cell.
REQ-014 IDLE: start=1 at edge k latches a, (b XOR {WIDTH{sub}}) and carry=sub, clears bit counter, enters RUN.
REQ-015 RUN: each edge adds operand bit i, B bit i and the carry flop; shifts the sum bit into result MSB; updates carry; increments counter.
REQ-016 After the WIDTH-th RUN edge (edge k+WIDTH), state = DONE; done=1 for exactly that cycle; busy=0.
REQ-017 Latency: start sampled at edge k -> done high from edge k+WIDTH to edge k+WIDTH+1.
REQ-018 DONE -> IDLE at the next edge unless start=1, in which case new operands are latched and state = RUN (back-to-back).
REQ-019 start while in RUN is ignored; latched operands and op do not change.
REQ-020 result, carry_out, overflow hold their last values in IDLE until the next DONE; result bits are undefined-by-contract during RUN (shift in progress).
REQ-021 overflow = carry into MSB XOR carry out of MSB, captured on the final RUN edge.
REQ-022 Width rule: no internal result wider than WIDTH; counter width = clog2(WIDTH)+1.

Reset
REQ-023 rst=1 immediately (asynchronously) forces state IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, counter=0, carry flop=0.
REQ-024 Reset mid-RUN aborts the operation; no done pulse is produced for it; first start after rst deasserts behaves per REQ-014.

Structure
REQ-025 Shared package serial_addsub_pkg holds the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the default WIDTH constant.
REQ-026 One sub-module, fa_bit (inputs x, y, cin; outputs s, cout), purely combinational, instantiated once; all sequencing stays in serial_addsub.

Verification (WIDTH=8)
REQ-027 add 0x05+0x03 -> done 8 cycles after start edge; result=0x08, carry_out=0, overflow=0.
REQ-028 add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
REQ-029 sub 0x05-0x07 -> result=0xFE, carry_out=0 (borrow), overflow=0; sub 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
REQ-030 start pulsed again 3 cycles into RUN with different operands -> ignored; first result delivered unchanged at the original done cycle.
REQ-031 rst asserted 4 cycles into RUN (between edges) -> outputs zero immediately, no done pulse; next start 0x10+0x20 -> result=0x30.
REQ-032 start held high through DONE -> back-to-back operations, done pulses exactly every 9 cycles.
